fp_sub_seq: RTL and testbench
=============================

FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 Port clk input 1: single clock; all state changes on the rising edge.
REQ-002 Port rst_n input 1: reset, asynchronous assert, active-low.
REQ-003 Port a input 32: IEEE-754 single-precision minuend.
REQ-004 Port b input 32: IEEE-754 single-precision subtrahend.
REQ-005 Port in_valid input 1: a/b valid.
REQ-006 Port in_ready output 1: block can accept an operand pair.
REQ-007 Port result output 32: a - b, IEEE-754 single precision.
REQ-008 Port out_valid output 1: result valid.
REQ-009 Port out_ready input 1: consumer accepts result.
REQ-010 Parameter none; the format is fixed at 1/8/23, bias 127.

Function
REQ-011 Operand pair SHALL be captured only on a clk edge with in_valid && in_ready; a and b are don't-care otherwise.
REQ-012 in_ready SHALL be 1 only in state IDLE.
REQ-013 FSM SHALL have states IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND, DONE.
REQ-014 IDLE->UNPACK on accept; UNPACK->DONE if a special case applies (REQ-020..023), else UNPACK->ALIGN.
REQ-015 UNPACK SHALL invert b's sign, restore hidden bits and swap operands so the larger magnitude is the first operand; the exponent difference is clamped to 27.
REQ-016 ALIGN SHALL right-shift the smaller mantissa 1 bit per cycle until the difference is 0, ORing shifted-out bits into a sticky bit; it then moves to ADDSUB.
REQ-017 ADDSUB (1 cycle) SHALL add the mantissas if the effective signs match and subtract them otherwise, using a 27-bit datapath (hidden+23+guard+round+sticky) plus a carry bit.
REQ-018 NORM SHALL handle carry-out with one right shift and exponent+1 in a single cycle; otherwise it left-shifts 1 bit per cycle with exponent-1 until bit 26 is 1. A zero mantissa exits to DONE with result 32'h00000000.
REQ-019 ROUND (1 cycle) SHALL apply round-to-nearest-even on guard/round/sticky; a mantissa carry renormalizes and increments the exponent.
REQ-020 Any NaN input, or inf - inf with the same sign, SHALL give 32'h7FC00000.
REQ-021 A single infinite operand SHALL give that infinity with the effective sign.
REQ-022 Denormal inputs SHALL be treated as zero; if both operands are zero, result = +0 unless a=-0 and b=+0, which gives 32'h80000000.
REQ-023 A zero operand SHALL give the other operand, with b negated, without arithmetic.
REQ-024 Exponent overflow (>=255) after NORM/ROUND SHALL give signed infinity; underflow (<=0) SHALL give signed zero (flush).
REQ-025 Exact cancellation of nonzero operands SHALL give +0 (32'h00000000).
REQ-026 In DONE, out_valid=1 and result SHALL be held stable until out_ready=1; DONE->IDLE on out_valid && out_ready.
REQ-027 in_ready SHALL be 0 in DONE even when out_ready=1; the next operand is accepted no earlier than the cycle after handoff.
REQ-028 Worst-case latency from accept to out_valid SHALL be at most 56 cycles; a same-exponent add without normalization SHALL take exactly 5 cycles (UNPACK, ALIGN, ADDSUB, NORM, ROUND).

Reset
REQ-029 rst_n low SHALL force IDLE immediately, aborting any operation in progress with no output.
REQ-030 Reset values SHALL be: result=32'h0, out_valid=0, in_ready=1 (in IDLE), and all internal registers 0.
REQ-031 Release SHALL be synchronized by the system; the block is ready on the first edge after release.

Structure
REQ-032 Shared package fp_pkg SHALL hold the FSM state enum, field widths (EXP_W=8, MAN_W=23), BIAS=127, QNAN=32'h7FC00000, POS_INF/NEG_INF, and the clamp value 27.
REQ-033 One combinational sub-module, fp_classify, SHALL decode an operand into zero/denormal/inf/NaN flags plus sign/exponent/mantissa; it is instantiated twice.

Verification
REQ-034 a=44000000, b=41B40000 (512-22.5) -> result=43F4C000 (489.5), out_valid held until out_ready.
REQ-035 a=3F800000, b=40000000 (1-2) -> BF800000; a=43695553, b=43695553 -> 00000000.
REQ-036 a=7F800000, b=7F800000 -> 7FC00000; a=7F7FFFFF, b=FF7FFFFF -> 7F800000 (overflow); a=00000001, b=00000000 -> 00000000.
REQ-037 out_ready held low 5 cycles in DONE -> result/out_valid stable, in_ready=0 throughout; accept occurs the cycle after handoff.
REQ-038 rst_n pulsed low mid-ALIGN -> out_valid=0, in_ready=1 immediately; the next operation completes correctly.
REQ-039 Random normal operands vs. a reference model (RNE, flush-to-zero) -> bit-exact match; latency <=56 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the sequential single-precision subtractor
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;
  localparam int M_W   = 27;

  localparam logic [4:0]  DIFF_MAX = 5'd27;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;
  localparam logic [31:0] NEG_INF  = 32'hFF800000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADDSUB = 3'd3,
    S_NORM   = 3'd4,
    S_ROUND  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational field split and class flags for one single-precision operand
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0]      op,
  output logic             sign,
  output logic [EXP_W-1:0] expo,
  output logic [MAN_W-1:0] man,
  output logic             is_zero,
  output logic             is_denorm,
  output logic             is_inf,
  output logic             is_nan
);

  always_comb begin
    sign      = op[31];
    expo      = op[30:23];
    man       = op[22:0];
    is_zero   = (expo == '0) && (man == '0);
    is_denorm = (expo == '0) && (man != '0);
    is_inf    = (expo == '1) && (man == '0);
    is_nan    = (expo == '1) && (man != '0);
  end

endmodule

// File: rtl/fp_sub_seq.sv
// rtl/fp_sub_seq.sv - multi-cycle IEEE-754 single-precision a - b, RNE, denormals flushed
module fp_sub_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, res_q, res_d;
  logic               sign_q, sign_d, sub_q, sub_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [M_W:0]       ma_q, ma_d;
  logic [M_W-1:0]     mb_q, mb_d;
  logic [4:0]         diff_q, diff_d;

  logic               a_sign, a_zero, a_den, a_inf, a_nan;
  logic               b_sign, b_zero, b_den, b_inf, b_nan;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_man, b_man;

  fp_classify u_cls_a (
    .op(a_q), .sign(a_sign), .expo(a_exp), .man(a_man),
    .is_zero(a_zero), .is_denorm(a_den), .is_inf(a_inf), .is_nan(a_nan)
  );

  fp_classify u_cls_b (
    .op(b_q), .sign(b_sign), .expo(b_exp), .man(b_man),
    .is_zero(b_zero), .is_denorm(b_den), .is_inf(b_inf), .is_nan(b_nan)
  );

  logic               sb_eff, az, bz, special, a_big;
  logic [31:0]        special_res;
  logic [7:0]         ediff;
  logic               rnd_up;
  logic [24:0]        rnd;
  logic signed [9:0]  rnd_exp;

  // Special operands bypass the arithmetic path entirely.
  always_comb begin
    sb_eff      = ~b_sign;
    az          = a_zero | a_den;
    bz          = b_zero | b_den;
    special     = 1'b1;
    special_res = QNAN;
    if (a_nan || b_nan)     special_res = QNAN;
    else if (a_inf && b_inf) special_res = (a_sign == sb_eff) ? (a_sign ? NEG_INF : POS_INF) : QNAN;
    else if (a_inf)          special_res = a_sign ? NEG_INF : POS_INF;
    else if (b_inf)          special_res = sb_eff ? NEG_INF : POS_INF;
    else if (az && bz)       special_res = {a_sign & sb_eff, 31'd0};
    else if (az)             special_res = {sb_eff, b_q[30:0]};
    else if (bz)             special_res = a_q;
    else                     special     = 1'b0;
    a_big = (a_q[30:0] >= b_q[30:0]);
    ediff = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
  end

  // Mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
  always_comb begin
    rnd_up  = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
    rnd     = {1'b0, ma_q[26:3]} + {24'd0, rnd_up};
    rnd_exp = rnd[24] ? exp_q + 10'sd1 : exp_q;
  end

  always_comb begin
    a_d = a_q; b_d = b_q; res_d = res_q; sign_d = sign_q; sub_d = sub_q;
    exp_d = exp_q; ma_d = ma_q; mb_d = mb_q; diff_d = diff_q;
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
      end
      S_UNPACK: begin
        if (special) begin
          res_d = special_res;
        end else begin
          sub_d = a_sign ^ sb_eff;
          if (a_big) begin
            sign_d = a_sign;
            exp_d  = {2'b00, a_exp};
            ma_d   = {2'b01, a_man, 3'b000};
            mb_d   = {1'b1, b_man, 3'b000};
          end else begin
            sign_d = sb_eff;
            exp_d  = {2'b00, b_exp};
            ma_d   = {2'b01, b_man, 3'b000};
            mb_d   = {1'b1, a_man, 3'b000};
          end
          diff_d = (ediff > {3'd0, DIFF_MAX}) ? DIFF_MAX : ediff[4:0];
        end
      end
      S_ALIGN: if (diff_q != 5'd0) begin
        mb_d   = {1'b0, mb_q[26:2], mb_q[1] | mb_q[0]};
        diff_d = diff_q - 5'd1;
      end
      S_ADDSUB: ma_d = sub_q ? (ma_q - {1'b0, mb_q}) : (ma_q + {1'b0, mb_q});
      S_NORM: begin
        if (ma_q[27]) begin
          ma_d  = {1'b0, ma_q[27:2], ma_q[1] | ma_q[0]};
          exp_d = exp_q + 10'sd1;
        end else if (ma_q == '0) begin
          res_d = 32'h0000_0000;
        end else if (!ma_q[26]) begin
          ma_d  = ma_q << 1;
          exp_d = exp_q - 10'sd1;
        end
      end
      S_ROUND: begin
        if (rnd_exp >= EXP_MAX)  res_d = sign_q ? NEG_INF : POS_INF;
        else if (rnd_exp <= 0)   res_d = {sign_q, 31'd0};
        else                     res_d = {sign_q, rnd_exp[7:0], rnd[22:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = S_UNPACK;
      S_UNPACK: state_d = special ? S_DONE : S_ALIGN;
      S_ALIGN:  if (diff_q == 5'd0) state_d = S_ADDSUB;
      S_ADDSUB: state_d = S_NORM;
      S_NORM: begin
        if (ma_q[27] || ma_q[26] || ma_q[25]) state_d = S_ROUND;
        else if (ma_q == '0)                  state_d = S_DONE;
      end
      S_ROUND:  state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = res_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; res_q <= '0; sign_q <= 1'b0; sub_q <= 1'b0;
      exp_q <= '0; ma_q <= '0; mb_q <= '0; diff_q <= '0;
    end else begin
      a_q <= a_d; b_q <= b_d; res_q <= res_d; sign_q <= sign_d; sub_q <= sub_d;
      exp_q <= exp_d; ma_q <= ma_d; mb_q <= mb_d; diff_q <= diff_d;
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb/tb_fp_sub_seq.sv - directed and reference-model checks for fp_sub_seq
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  fp_sub_seq dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  // Double-precision difference is exact enough that a single RNE rounding of it is correct.
  function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] d;
    logic [24:0] keep;
    logic        up;
    int          e;
    d = $realtobits(f2r(x) - f2r(y));
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e    = int'(d[62:52]) - 896;
    keep = {2'b01, d[51:29]};
    up   = d[28] & ((|d[27:0]) | keep[0]);
    keep = keep + {24'd0, up};
    if (keep[24]) begin
      e++;
      keep = keep >> 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], e[7:0], keep[22:0]};
  endfunction

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check32({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] er,
                        input string tag, input int want_lat);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    wait_valid(tag, lat);
    check32({tag, "_res"}, result, er);
    if (want_lat >= 0) check32({tag, "_lat"}, 32'(lat), 32'(want_lat));
    else               check32({tag, "_latmax"}, {31'd0, lat <= 56}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check32({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [7:0]  ea, eb;
    int          lat;

    #12;
    check32("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h44000000, 32'h41B40000, 32'h43F4C000, "sub_512_22p5", -1);
    run_op(32'h3F800000, 32'h40000000, 32'hBF800000, "one_minus_two", -1);
    run_op(32'h43695553, 32'h43695553, 32'h00000000, "cancel", -1);
    run_op(32'h3F800000, 32'hBF800000, 32'h40000000, "same_exp_add", 5);
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf_minus_inf", -1);
    run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, "overflow", -1);
    run_op(32'h00000001, 32'h00000000, 32'h00000000, "denorm_zero", -1);
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in", -1);
    run_op(32'h3F800000, 32'h7F800000, 32'hFF800000, "inf_b", -1);
    run_op(32'h00000000, 32'h40400000, 32'hC0400000, "zero_a", -1);
    run_op(32'h40400000, 32'h80000000, 32'h40400000, "zero_b", -1);
    run_op(32'h80000000, 32'h00000000, 32'h80000000, "negz_posz", -1);
    run_op(32'h80000000, 32'h80000000, 32'h00000000, "negz_negz", -1);
    run_op(32'h3F800000, 32'hB3800000, 32'h3F800000, "rne_tie_even", -1);
    run_op(32'h3F800001, 32'hB3800000, 32'h3F800002, "rne_tie_odd", -1);
    run_op(32'h40000000, 32'h00400000, 32'h40000000, "denorm_b", -1);
    run_op(32'h00800001, 32'h00800000, 32'h00000000, "underflow_pos", -1);
    run_op(32'h00800000, 32'h00800001, 32'h80000000, "underflow_neg", -1);
    run_op(32'h7F000000, 32'h3F800000, 32'h7F000000, "clamp_diff", -1);

    // Output stall: result held, no accept while DONE, accept only after handoff.
    @(negedge clk);
    a = 32'h44000000; b = 32'h41B40000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("stall", lat);
    for (int k = 0; k < 5; k++) begin
      check32("stall_res", result, 32'h43F4C000);
      check32("stall_valid", {31'd0, out_valid}, 32'd1);
      check32("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    a = 32'h3F800000; b = 32'hBF800000; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check32("done_in_ready_ordy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check32("handoff_idle", {30'd0, in_ready, out_valid}, 32'h2);
    @(negedge clk);
    in_valid = 1'b0;
    check32("accept_after_handoff", {31'd0, in_ready}, 32'd0);
    wait_valid("post_stall", lat);
    check32("post_stall_res", result, 32'h40000000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of alignment.
    @(negedge clk);
    a = 32'h4B000000; b = 32'h3F800000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check32("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check32("midrst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h3F800000, 32'h40000000, 32'hBF800000, "post_rst", -1);

    for (int i = 0; i < 16; i++) begin
      ea = 8'($urandom_range(110, 144));
      eb = (i % 2 == 1) ? ea + 8'($urandom_range(0, 2)) - 8'd1 : 8'($urandom_range(110, 144));
      x  = {1'($urandom), ea, 23'($urandom)};
      y  = {1'($urandom), eb, 23'($urandom)};
      if (i == 14) y = {~x[31], x[30:0]};
      if (i == 15) y = x;
      run_op(x, y, ref_sub(x, y), "rand", -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
